// File: rtl/dmem_responder_if.sv
// Memory-stage request/response bundle between the pipeline and the data-memory responder.
// Latency: none (wires only).
// Backpressure: the responder drives stall while an access it has accepted is still in flight.
//
// Signals:
//   req      - access valid (load or store), held by the pipeline while stall=1
//   we       - 1 = store, 0 = load
//   sb       - byte store, meaningful only with we=1
//   addr     - byte address from the memory-stage ALU
//   wdata    - store data (sb uses wdata[7:0])
//   rdata    - registered read word
//   ready    - one-cycle completion pulse
//   stall    - pipeline hold request
//   misalign - one-cycle error pulse, coincident with ready
interface dmem_responder_if;
   logic        req;
   logic        we;
   logic        sb;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        stall;
   logic        misalign;

   modport slave (
      input  req, we, sb, addr, wdata,
      output rdata, ready, stall, misalign
   );

   modport master (
      output req, we, sb, addr, wdata,
      input  rdata, ready, stall, misalign
   );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: word loads, word stores and byte stores into a word array.
// Latency: ready/rdata/misalign LATENCY+1 cycles after req is first seen in IDLE; LATENCY+2 cycles per access.
// Backpressure: stall = req & ~ready holds the pipeline; inputs are captured once and never re-sampled.
//
// Ports:
//   clk   - clock
//   reset - synchronous, active-high; abandons an in-flight access, leaves the array intact
//   bus   - dmem_responder_if.slave (req/we/sb/addr/wdata in, rdata/ready/stall/misalign out)
module dmem_responder #(
   parameter int ADDR_WIDTH = 8,
   parameter int LATENCY    = 2
) (
   input  logic             clk,
   input  logic             reset,
   dmem_responder_if.slave  bus
);

   localparam int         DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [3:0] LAT   = 4'(LATENCY);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [31:0]             rdata_q, rdata_d;
   logic                    we_q, sb_q;
   logic [ADDR_WIDTH+1:0]   addr_q;
   logic [31:0]             wdata_q;
   logic                    cap_en;

   logic [31:0]             mem [DEPTH];

   logic [ADDR_WIDTH-1:0]   idx_q;
   logic [1:0]              lane_q;
   logic                    ready_w;
   logic                    wr_word;
   logic                    wr_byte;

   // Upper address bits are dropped on capture, so addresses alias modulo the array size.
   assign idx_q   = addr_q[ADDR_WIDTH+1:2];
   assign lane_q  = addr_q[1:0];
   assign ready_w = (state_q == ST_DONE);

   // Stores commit on the edge that ends DONE; a misaligned word store is dropped.
   assign wr_word = ready_w & we_q & ~sb_q & (lane_q == 2'b00);
   assign wr_byte = ready_w & we_q & sb_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      cap_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req) begin
               cap_en = 1'b1;
               cnt_d  = LAT;
               if (LAT == 4'd0) begin
                  // No wait states: the captured registers are not valid yet,
                  // so the load word comes straight from the live address.
                  state_d = ST_DONE;
                  if (!bus.we) begin
                     rdata_d = mem[bus.addr[ADDR_WIDTH+1:2]];
                  end
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               state_d = ST_DONE;
               if (!we_q) begin
                  rdata_d = mem[idx_q];
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         we_q    <= 1'b0;
         sb_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         if (cap_en) begin
            we_q    <= bus.we;
            sb_q    <= bus.sb;
            addr_q  <= bus.addr[ADDR_WIDTH+1:0];
            wdata_q <= bus.wdata;
         end
      end
   end

   // Array has no reset; reset only blocks a pending commit.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (wr_word) begin
            mem[idx_q] <= wdata_q;
         end else if (wr_byte) begin
            mem[idx_q][{lane_q, 3'b000} +: 8] <= wdata_q[7:0];
         end
      end
   end

   assign bus.rdata    = rdata_q;
   assign bus.ready    = ready_w;
   assign bus.misalign = ready_w & we_q & ~sb_q & (lane_q != 2'b00);
   assign bus.stall    = bus.req & ~ready_w;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst2 = 1'b1;
   logic rst3 = 1'b1;
   logic rst0 = 1'b1;

   dmem_responder_if if2 ();
   dmem_responder_if if3 ();
   dmem_responder_if if0 ();

   dmem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) u_l2 (.clk(clk), .reset(rst2), .bus(if2.slave));
   dmem_responder #(.ADDR_WIDTH(8), .LATENCY(3)) u_l3 (.clk(clk), .reset(rst3), .bus(if3.slave));
   dmem_responder #(.ADDR_WIDTH(8), .LATENCY(0)) u_l0 (.clk(clk), .reset(rst0), .bus(if0.slave));

   int          sel = 2;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic        d_sb = 1'b0;
   logic [31:0] d_addr = 32'd0;
   logic [31:0] d_wdata = 32'd0;

   assign if2.req = (sel == 2) ? d_req : 1'b0;
   assign if3.req = (sel == 3) ? d_req : 1'b0;
   assign if0.req = (sel == 0) ? d_req : 1'b0;
   assign if2.we = d_we;     assign if3.we = d_we;     assign if0.we = d_we;
   assign if2.sb = d_sb;     assign if3.sb = d_sb;     assign if0.sb = d_sb;
   assign if2.addr = d_addr; assign if3.addr = d_addr; assign if0.addr = d_addr;
   assign if2.wdata = d_wdata; assign if3.wdata = d_wdata; assign if0.wdata = d_wdata;

   logic [31:0] o_rdata;
   logic        o_ready, o_stall, o_mis;
   always_comb begin
      o_rdata = if0.rdata; o_ready = if0.ready; o_stall = if0.stall; o_mis = if0.misalign;
      if (sel == 2) begin
         o_rdata = if2.rdata; o_ready = if2.ready; o_stall = if2.stall; o_mis = if2.misalign;
      end else if (sel == 3) begin
         o_rdata = if3.rdata; o_ready = if3.ready; o_stall = if3.stall; o_mis = if3.misalign;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   int          nst, idx, rdy_abs, prev_abs;
   logic [31:0] rd;
   logic        mis, tmo;

   // Drives one access starting in an IDLE cycle; returns stall count, ready offset and response.
   task automatic access(input logic we, input logic sb, input logic [31:0] addr, input logic [31:0] wdata,
                         output int nstall, output int rdy_idx, output logic [31:0] rdv,
                         output logic misv, output logic tmov);
      d_we = we; d_sb = sb; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
      nstall = 0; rdy_idx = -1; rdv = 32'd0; misv = 1'b0; tmov = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (o_stall) nstall++;
         if (o_ready) begin
            rdy_idx = i; rdv = o_rdata; misv = o_mis; rdy_abs = cyc; tmov = 1'b0;
            break;
         end
      end
      @(posedge clk); #1;
      d_req = 1'b0;
   endtask

   task automatic test_reset();
      sel = 2;
      @(posedge clk); #1;
      rst2 = 1'b1; rst3 = 1'b1; rst0 = 1'b1; d_req = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      n_chk++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL rst_stall_req1: got %b expected 1", o_stall); end
      n_chk++; if (o_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b expected 0", o_ready); end
      n_chk++; if (o_mis !== 1'b0) begin n_err++; $display("FAIL rst_misalign: got %b expected 0", o_mis); end
      n_chk++; if (o_rdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata: got %h expected 00000000", o_rdata); end
      n_chk++; if (if3.rdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata_l3: got %h expected 00000000", if3.rdata); end
      n_chk++; if (if0.rdata !== 32'd0) begin n_err++; $display("FAIL rst_rdata_l0: got %h expected 00000000", if0.rdata); end
      @(posedge clk); #1;
      d_req = 1'b0;
      @(negedge clk);
      n_chk++; if (o_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall_req0: got %b expected 0", o_stall); end
      @(posedge clk); #1;
      rst2 = 1'b0; rst3 = 1'b0; rst0 = 1'b0;
   endtask

   task automatic test_word_roundtrip();
      sel = 2;
      access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, nst, idx, rd, mis, tmo);
      n_chk++; if (tmo !== 1'b0) begin n_err++; $display("FAIL rt_sw_timeout: got %b expected 0", tmo); end
      n_chk++; if (nst !== 3) begin n_err++; $display("FAIL rt_sw_stall_cycles: got %0d expected 3", nst); end
      n_chk++; if (idx !== 3) begin n_err++; $display("FAIL rt_sw_ready_cycle: got %0d expected 3", idx); end
      n_chk++; if (mis !== 1'b0) begin n_err++; $display("FAIL rt_sw_misalign: got %b expected 0", mis); end
      access(1'b0, 1'b0, 32'h10, 32'h0, nst, idx, rd, mis, tmo);
      n_chk++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL rt_lw10_rdata: got %h expected deadbeef", rd); end
      n_chk++; if (idx !== 3) begin n_err++; $display("FAIL rt_lw10_ready_cycle: got %0d expected 3", idx); end
      access(1'b0, 1'b0, 32'h13, 32'h0, nst, idx, rd, mis, tmo);
      n_chk++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL rt_lw13_rdata: got %h expected deadbeef", rd); end
      n_chk++; if (mis !== 1'b0) begin n_err++; $display("FAIL rt_lw13_misalign: got %b expected 0", mis); end
   endtask

   task automatic test_byte_stores();
      sel = 2;
      access(1'b1, 1'b0, 32'h20, 32'h00000000, nst, idx, rd, mis, tmo);
      access(1'b1, 1'b1, 32'h21, 32'h123456AA, nst, idx, rd, mis, tmo);
      n_chk++; if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL sb_rdata_hold: got %h expected deadbeef", rd); end
      n_chk++; if (mis !== 1'b0) begin n_err++; $display("FAIL sb_misalign: got %b expected 0", mis); end
      access(1'b1, 1'b1, 32'h23, 32'hABCDEF55, nst, idx, rd, mis, tmo);
      access(1'b0, 1'b0, 32'h20, 32'h0, nst, idx, rd, mis, tmo);
      n_chk++; if (rd !== 32'h5500AA00) begin n_err++; $display("FAIL sb_lw20_rdata: got %h expected 5500aa00", rd); end
   endtask

   task automatic test_misalign();
      sel = 2;
      access(1'b1, 1'b0, 32'h30, 32'h0BADF00D, nst, idx, rd, mis, tmo);
      n_chk++; if (mis !== 1'b0) begin n_err++; $display("FAIL mis_aligned_sw: got %b expected 0", mis); end
      access(1'b1, 1'b0, 32'h31, 32'h12345678, nst, idx, rd, mis, tmo);
      n_chk++; if (mis !== 1'b1) begin n_err++; $display("FAIL mis_sw31_flag: got %b expected 1", mis); end
      n_chk++; if (idx !== 3) begin n_err++; $display("FAIL mis_sw31_ready_cycle: got %0d expected 3", idx); end
      @(negedge clk);
      n_chk++; if (o_mis !== 1'b0) begin n_err++; $display("FAIL mis_pulse_width: got %b expected 0", o_mis); end
      @(posedge clk); #1;
      access(1'b0, 1'b0, 32'h30, 32'h0, nst, idx, rd, mis, tmo);
      n_chk++; if (rd !== 32'h0BADF00D) begin n_err++; $display("FAIL mis_lw30_rdata: got %h expected 0badf00d", rd); end
   endtask

   task automatic test_req_drop();
      logic seen;
      logic stall_bad;
      logic [31:0] rdv;
      sel = 2;
      seen = 1'b0; stall_bad = 1'b0; rdv = 32'd0;
      d_we = 1'b0; d_sb = 1'b0; d_addr = 32'h10; d_req = 1'b1;
      @(posedge clk); #1;
      d_req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (o_stall) stall_bad = 1'b1;
         if (o_ready) begin seen = 1'b1; rdv = o_rdata; break; end
      end
      @(posedge clk); #1;
      n_chk++; if (seen !== 1'b1) begin n_err++; $display("FAIL drop_ready_seen: got %b expected 1", seen); end
      n_chk++; if (stall_bad !== 1'b0) begin n_err++; $display("FAIL drop_stall: got %b expected 0", stall_bad); end
      n_chk++; if (rdv !== 32'hDEADBEEF) begin n_err++; $display("FAIL drop_rdata: got %h expected deadbeef", rdv); end
   endtask

   task automatic test_reset_mid();
      logic seen;
      sel = 3;
      seen = 1'b0;
      access(1'b1, 1'b0, 32'h40, 32'h11112222, nst, idx, rd, mis, tmo);
      n_chk++; if (nst !== 4) begin n_err++; $display("FAIL rm_l3_stall_cycles: got %0d expected 4", nst); end
      n_chk++; if (idx !== 4) begin n_err++; $display("FAIL rm_l3_ready_cycle: got %0d expected 4", idx); end
      d_we = 1'b1; d_sb = 1'b0; d_addr = 32'h40; d_wdata = 32'hCAFEF00D; d_req = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst3 = 1'b1; d_req = 1'b0;
      @(posedge clk); #1;
      rst3 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (o_ready) seen = 1'b1;
      end
      @(posedge clk); #1;
      n_chk++; if (seen !== 1'b0) begin n_err++; $display("FAIL rm_ready_after_reset: got %b expected 0", seen); end
      access(1'b0, 1'b0, 32'h40, 32'h0, nst, idx, rd, mis, tmo);
      n_chk++; if (tmo !== 1'b0) begin n_err++; $display("FAIL rm_lw40_timeout: got %b expected 0", tmo); end
      n_chk++; if (idx !== 4) begin n_err++; $display("FAIL rm_lw40_ready_cycle: got %0d expected 4", idx); end
      n_chk++; if (rd !== 32'h11112222) begin n_err++; $display("FAIL rm_lw40_rdata: got %h expected 11112222", rd); end
   endtask

   task automatic test_back_to_back();
      sel = 0;
      access(1'b1, 1'b0, 32'h0, 32'h00000001, nst, idx, rd, mis, tmo);
      n_chk++; if (nst !== 1) begin n_err++; $display("FAIL b2b_sw0_stall_cycles: got %0d expected 1", nst); end
      n_chk++; if (idx !== 1) begin n_err++; $display("FAIL b2b_sw0_ready_cycle: got %0d expected 1", idx); end
      prev_abs = rdy_abs;
      access(1'b1, 1'b0, 32'h400, 32'h00000002, nst, idx, rd, mis, tmo);
      n_chk++; if (nst !== 1) begin n_err++; $display("FAIL b2b_sw400_stall_cycles: got %0d expected 1", nst); end
      n_chk++; if (rdy_abs - prev_abs !== 2) begin n_err++; $display("FAIL b2b_sw400_spacing: got %0d expected 2", rdy_abs - prev_abs); end
      prev_abs = rdy_abs;
      access(1'b0, 1'b0, 32'h0, 32'h0, nst, idx, rd, mis, tmo);
      n_chk++; if (rd !== 32'h00000002) begin n_err++; $display("FAIL b2b_lw0_rdata: got %h expected 00000002", rd); end
      n_chk++; if (rdy_abs - prev_abs !== 2) begin n_err++; $display("FAIL b2b_lw0_spacing: got %0d expected 2", rdy_abs - prev_abs); end
      n_chk++; if (nst !== 1) begin n_err++; $display("FAIL b2b_lw0_stall_cycles: got %0d expected 1", nst); end
   endtask

   initial begin
      test_reset();
      test_word_roundtrip();
      test_byte_stores();
      test_misalign();
      test_req_drop();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
